// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter: N_IDS cores share one memory_controller port.
// Latches the granted request; returns ack and read data to that core only.
module bus_arbiter_rr #(
   parameter  int N_IDS = 2,
   localparam int ID_W  = $clog2(N_IDS)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [N_IDS-1:0]      i_m_bus_en,
   input  logic [N_IDS-1:0]      i_m_wr_en,
   input  logic [32*N_IDS-1:0]   i_m_wr_data,
   input  logic [32*N_IDS-1:0]   i_m_addr,
   input  logic [4*N_IDS-1:0]    i_m_byte_en,
   input  logic [N_IDS-1:0]      i_m_atomic,
   input  logic [7*N_IDS-1:0]    i_m_operation,
   output logic [N_IDS-1:0]      o_m_ack,
   output logic [31:0]           o_m_rd_data,
   output logic                  o_bus_en,
   output logic                  o_wr_en,
   output logic [31:0]           o_wr_data,
   output logic [31:0]           o_addr,
   output logic [3:0]            o_byte_en,
   output logic                  o_atomic,
   output logic [6:0]            o_operation,
   output logic [ID_W-1:0]       o_id,
   output logic [N_IDS-1:0]      o_grant,
   input  logic                  i_ack,
   input  logic [31:0]           i_rd_data
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] pick;
   logic [ID_W-1:0] idx_w;
   logic            found;
   logic            grant_ld;
   logic            clr;
   logic            ptr_ld;
   int              idx;

   // First requester at or after rr_ptr, wrapping modulo N_IDS.
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      idx   = 0;
      idx_w = '0;
      for (int i = 0; i < N_IDS; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_IDS) idx = idx - N_IDS;
         idx_w = ID_W'(idx);
         if (!found && i_m_bus_en[idx_w]) begin
            found = 1'b1;
            pick  = idx_w;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_ld    = 1'b0;
      clr         = 1'b0;
      ptr_ld      = 1'b0;
      o_bus_en    = 1'b0;
      o_m_ack     = '0;
      o_m_rd_data = '0;
      unique case (state_q)
         IDLE: begin
            if (|i_m_bus_en) begin
               grant_ld = 1'b1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            // Low in the ack cycle so the controller does not restart.
            o_bus_en = !i_ack;
            if (i_ack) begin
               o_m_ack[o_id] = 1'b1;
               o_m_rd_data   = i_rd_data;
               ptr_ld        = 1'b1;
               clr           = 1'b1;
               state_d       = RELEASE;
            end
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= IDLE;
         rr_ptr  <= '0;
      end else begin
         state_q <= state_d;
         if (ptr_ld)
            rr_ptr <= (o_id == ID_W'(N_IDS-1)) ? '0 : o_id + 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_id        <= '0;
         o_grant     <= '0;
         o_wr_en     <= 1'b0;
         o_wr_data   <= '0;
         o_addr      <= '0;
         o_byte_en   <= '0;
         o_atomic    <= 1'b0;
         o_operation <= '0;
      end else if (grant_ld) begin
         o_id        <= pick;
         o_grant     <= {{(N_IDS-1){1'b0}}, 1'b1} << pick;
         o_wr_en     <= i_m_wr_en[pick];
         o_wr_data   <= i_m_wr_data[32*pick +: 32];
         o_addr      <= i_m_addr[32*pick +: 32];
         o_byte_en   <= i_m_byte_en[4*pick +: 4];
         o_atomic    <= i_m_atomic[pick];
         o_operation <= i_m_operation[7*pick +: 7];
      end else if (clr) begin
         o_id        <= '0;
         o_grant     <= '0;
         o_wr_en     <= 1'b0;
         o_wr_data   <= '0;
         o_addr      <= '0;
         o_byte_en   <= '0;
         o_atomic    <= 1'b0;
         o_operation <= '0;
      end
   end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr with two cores.
// Expected values are hand-derived from the round-robin rules.
module tb_bus_arbiter_rr;

   localparam int N = 2;

   logic          clk;
   logic          rst;
   logic [N-1:0]  m_bus_en;
   logic [N-1:0]  m_wr_en;
   logic [32*N-1:0] m_wr_data;
   logic [32*N-1:0] m_addr;
   logic [4*N-1:0]  m_byte_en;
   logic [N-1:0]  m_atomic;
   logic [7*N-1:0]  m_operation;
   logic [N-1:0]  m_ack;
   logic [31:0]   m_rd_data;
   logic          bus_en;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic [31:0]   addr;
   logic [3:0]    byte_en;
   logic          atomic;
   logic [6:0]    operation;
   logic          id;
   logic [N-1:0]  grant;
   logic          ack;
   logic [31:0]   rd_data;

   int n_chk = 0;
   int n_err = 0;

   bus_arbiter_rr #(.N_IDS(N)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_m_bus_en    (m_bus_en),
      .i_m_wr_en     (m_wr_en),
      .i_m_wr_data   (m_wr_data),
      .i_m_addr      (m_addr),
      .i_m_byte_en   (m_byte_en),
      .i_m_atomic    (m_atomic),
      .i_m_operation (m_operation),
      .o_m_ack       (m_ack),
      .o_m_rd_data   (m_rd_data),
      .o_bus_en      (bus_en),
      .o_wr_en       (wr_en),
      .o_wr_data     (wr_data),
      .o_addr        (addr),
      .o_byte_en     (byte_en),
      .o_atomic      (atomic),
      .o_operation   (operation),
      .o_id          (id),
      .o_grant       (grant),
      .i_ack         (ack),
      .i_rd_data     (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // From an IDLE negedge with requests set: one edge later the grant shows.
   task automatic grant_chk(input int k, input logic [31:0] exp_addr);
      @(negedge clk);
      check("id", 32'(id), 32'(k));
      check("grant", 32'(grant), 32'(1 << k));
      check("bus_en", 32'(bus_en), 32'd1);
      check("addr", addr, exp_addr);
      check("m_ack_busy", 32'(m_ack), 32'd0);
   endtask

   // Ack the BUSY transaction, check RELEASE, end at the IDLE negedge.
   task automatic ack_chk(input int k, input logic [31:0] rd);
      ack = 1'b1;
      rd_data = rd;
      #1;
      check("m_ack", 32'(m_ack), 32'(1 << k));
      check("m_rd_data", m_rd_data, rd);
      check("bus_en_ack", 32'(bus_en), 32'd0);
      @(negedge clk);
      ack = 1'b0;
      rd_data = '0;
      check("rel_grant", 32'(grant), 32'd0);
      check("rel_addr", addr, 32'd0);
      check("rel_bus_en", 32'(bus_en), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int exp;
      rst = 1'b0;
      m_bus_en = '0;
      m_wr_en = '0;
      m_wr_data = '0;
      m_addr = '0;
      m_byte_en = '0;
      m_atomic = '0;
      m_operation = '0;
      ack = 1'b0;
      rd_data = '0;
      repeat (2) @(negedge clk);
      check("rst_bus_en", 32'(bus_en), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_id", 32'(id), 32'd0);
      check("rst_addr", addr, 32'd0);
      check("rst_m_ack", 32'(m_ack), 32'd0);
      rst = 1'b1;

      // Single write from core 0
      m_bus_en = 2'b01;
      m_wr_en = 2'b01;
      m_addr[31:0] = 32'h100;
      m_wr_data[31:0] = 32'hDEADBEEF;
      m_byte_en[3:0] = 4'hF;
      grant_chk(0, 32'h100);
      check("wr_data", wr_data, 32'hDEADBEEF);
      check("byte_en", 32'(byte_en), 32'hF);
      check("wr_en", 32'(wr_en), 32'd1);
      ack_chk(0, 32'hCAFEF00D);

      // Both request continuously; rr_ptr is 1 after core 0 finished
      m_addr[63:32] = 32'h204;
      m_bus_en = 2'b11;
      exp = 1;
      for (int i = 0; i < 4; i++) begin
         grant_chk(exp, (exp == 1) ? 32'h204 : 32'h100);
         ack_chk(exp, 32'(i + 16));
         exp = exp ^ 1;
      end

      // Core 1 AMOADD; inputs change mid-BUSY
      m_bus_en = 2'b10;
      m_atomic = 2'b10;
      m_operation[13:7] = 7'b0000001;
      m_addr[63:32] = 32'h40;
      grant_chk(1, 32'h40);
      check("amo_op", 32'(operation), 32'h01);
      check("amo_atomic", 32'(atomic), 32'd1);
      m_addr[63:32] = 32'h44;
      m_operation[13:7] = 7'h7F;
      m_atomic = 2'b00;
      m_bus_en = 2'b11;
      m_addr[31:0] = 32'h300;
      @(negedge clk);
      check("hold_addr", addr, 32'h40);
      check("hold_op", 32'(operation), 32'h01);
      check("hold_id", 32'(id), 32'd1);
      check("hold_atomic", 32'(atomic), 32'd1);
      check("hold_bus_en", 32'(bus_en), 32'd1);
      ack_chk(1, 32'd0);

      // Core 0 LR then core 1 SC, same address
      m_atomic = 2'b11;
      m_operation[6:0] = {5'b00010, 2'b00};
      m_operation[13:7] = {5'b00011, 2'b00};
      m_addr[31:0] = 32'h80;
      m_addr[63:32] = 32'h80;
      m_wr_en = 2'b10;
      m_wr_data[63:32] = 32'h55;
      grant_chk(0, 32'h80);
      check("lr_op", 32'(operation), 32'h08);
      ack_chk(0, 32'h55);
      m_bus_en = 2'b10;
      grant_chk(1, 32'h80);
      check("sc_op", 32'(operation), 32'h0C);
      check("sc_data", wr_data, 32'h55);
      ack_chk(1, 32'd1);
      m_bus_en = 2'b00;

      // Stray ack in IDLE
      ack = 1'b1;
      rd_data = 32'hFFFF;
      #1;
      check("idle_m_ack", 32'(m_ack), 32'd0);
      check("idle_rd", m_rd_data, 32'd0);
      @(negedge clk);
      check("idle_bus_en", 32'(bus_en), 32'd0);
      check("idle_grant", 32'(grant), 32'd0);
      ack = 1'b0;
      rd_data = '0;
      @(negedge clk);
      check("idle_grant2", 32'(grant), 32'd0);

      // Reset mid-BUSY with rr_ptr at 1
      m_atomic = 2'b00;
      m_operation = '0;
      m_wr_en = '0;
      m_addr[31:0] = 32'h10;
      m_addr[63:32] = 32'h20;
      m_bus_en = 2'b01;
      grant_chk(0, 32'h10);
      ack_chk(0, 32'd0);
      m_bus_en = 2'b10;
      grant_chk(1, 32'h20);
      #2;
      rst = 1'b0;
      #1;
      check("arst_bus_en", 32'(bus_en), 32'd0);
      check("arst_grant", 32'(grant), 32'd0);
      check("arst_addr", addr, 32'd0);
      @(negedge clk);
      m_bus_en = 2'b11;
      rst = 1'b1;
      grant_chk(0, 32'h10);
      ack_chk(0, 32'h77);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
